// File: rtl/nn_pkg.sv
// nn_pkg: shared definitions for the neuron phase controller.
//   - default word width (Q8.8)
//   - phase codes driven to the neuron as {fp,bp}
//   - controller state enum
//   - cnt_w(): width of the run-length down-counter
package nn_pkg;

  localparam int BITS_DEF = 16;

  localparam logic [1:0] PH_FSETUP = 2'b00;
  localparam logic [1:0] PH_FWD    = 2'b10;
  localparam logic [1:0] PH_BSETUP = 2'b11;
  localparam logic [1:0] PH_BWD    = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FSETUP,
    S_FRUN,
    S_BSETUP,
    S_BRUN,
    S_FIN
  } nn_ctrl_state_t;

  // The counter is loaded with run length - 1, so $clog2 of the longer run
  // is enough. A floor of 1 bit keeps degenerate run lengths legal.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/neuron_phase_ctrl_if.sv
// neuron_phase_ctrl_if: bundle between the layer scheduler, the phase
// controller and one neuron instance.
//   scheduler side : start, train, dz_up, w_up -> ; <- busy, done, y_q, w_q
//   neuron side    : fp, bp, dz_in, w_in ->     ; <- y_nrn, w_nrn
//   abort          : only when NEURON_CTRL_ABORT_EN is defined
// Modports: slave = the controller, master = whatever drives it.
interface neuron_phase_ctrl_if #(
  parameter int N    = 6,
  parameter int BITS = nn_pkg::BITS_DEF
) ();

  logic                  start;
  logic                  train;
  logic [BITS-1:0]       dz_up;
  logic [BITS-1:0]       w_up;
  logic                  fp;
  logic                  bp;
  logic [BITS-1:0]       dz_in;
  logic [BITS-1:0]       w_in;
  logic [BITS-1:0]       y_nrn;
  logic [(N+1)*BITS-1:0] w_nrn;
  logic [BITS-1:0]       y_q;
  logic [(N+1)*BITS-1:0] w_q;
  logic                  busy;
  logic                  done;
`ifdef NEURON_CTRL_ABORT_EN
  logic                  abort;
`endif

  modport slave (
`ifdef NEURON_CTRL_ABORT_EN
    input  abort,
`endif
    input  start, train, dz_up, w_up, y_nrn, w_nrn,
    output fp, bp, dz_in, w_in, y_q, w_q, busy, done
  );

  modport master (
`ifdef NEURON_CTRL_ABORT_EN
    output abort,
`endif
    output start, train, dz_up, w_up, y_nrn, w_nrn,
    input  fp, bp, dz_in, w_in, y_q, w_q, busy, done
  );

endinterface

// File: rtl/nn_cycle_counter.sv
// nn_cycle_counter: loadable down-counter with zero flag.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load       : load load_val (wins over dec)
//   dec        : decrement; saturates at 0
//   cnt, zero  : current count, count == 0
module nn_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/neuron_phase_ctrl.sv
// neuron_phase_ctrl: sequences one neuron through forward (and optionally
// backward) passes with the {fp,bp} phase code.
//   clk, rst_n : clock, async active-low reset
//   bus        : neuron_phase_ctrl_if.slave (scheduler + neuron signals)
// Optional feature macro: NEURON_CTRL_ABORT_EN adds bus.abort, which forces
// FIN from any active state and skips captures not yet reached.
// Phase code, busy and done decode straight from the state register; data
// outputs are flops, so every output is glitch-free registered state.
module neuron_phase_ctrl
  import nn_pkg::*;
#(
  parameter int N       = 6,
  parameter int BITS    = BITS_DEF,
  parameter int FWD_RUN = N/2 + 4,
  parameter int BWD_RUN = N + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  neuron_phase_ctrl_if.slave bus
);

  localparam int CW = cnt_w(FWD_RUN, BWD_RUN);
  localparam int WW = (N+1)*BITS;
  localparam logic [CW-1:0] FWD_LD = CW'(FWD_RUN - 1);
  localparam logic [CW-1:0] BWD_LD = CW'(BWD_RUN - 1);

  nn_ctrl_state_t  state, nxt;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]   cnt_val, cnt;
  logic            cap_y, cap_w, accept, abort_hit;
  logic            train_r;
  logic [BITS-1:0] dz_r, w_r, y_r;
  logic [WW-1:0]   wq_r;
  logic [1:0]      ph;

`ifdef NEURON_CTRL_ABORT_EN
  assign abort_hit = bus.abort && (state != S_IDLE) && (state != S_FIN);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept  = (state == S_IDLE) && bus.start;
  assign cnt_dec = (state == S_FRUN) || (state == S_BRUN);

  nn_cycle_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_val  = FWD_LD;
    cap_y    = 1'b0;
    cap_w    = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) nxt = S_FSETUP;
      S_FSETUP: begin
        nxt      = S_FRUN;
        cnt_load = 1'b1;
        cnt_val  = FWD_LD;
      end
      S_FRUN:   if (cnt_zero) begin
        cap_y = 1'b1;
        nxt   = train_r ? S_BSETUP : S_FIN;
      end
      S_BSETUP: begin
        nxt      = S_BRUN;
        cnt_load = 1'b1;
        cnt_val  = BWD_LD;
      end
      S_BRUN:   if (cnt_zero) begin
        cap_w = 1'b1;
        nxt   = S_FIN;
      end
      S_FIN:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    // Abort beats any capture due on the same edge.
    if (abort_hit) begin
      nxt      = S_FIN;
      cnt_load = 1'b0;
      cap_y    = 1'b0;
      cap_w    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      train_r <= 1'b0;
      dz_r    <= '0;
      w_r     <= '0;
      y_r     <= '0;
      wq_r    <= '0;
    end else begin
      if (accept) begin
        train_r <= bus.train;
        dz_r    <= bus.dz_up;
        w_r     <= bus.w_up;
      end
      if (cap_y) y_r  <= bus.y_nrn;
      if (cap_w) wq_r <= bus.w_nrn;
    end
  end

  always_comb begin
    ph = PH_FSETUP;
    case (state)
      S_FRUN:   ph = PH_FWD;
      S_BSETUP: ph = PH_BSETUP;
      S_BRUN:   ph = PH_BWD;
      default:  ph = PH_FSETUP;
    endcase
  end

  assign bus.fp    = ph[1];
  assign bus.bp    = ph[0];
  assign bus.busy  = (state == S_FSETUP) || (state == S_FRUN) ||
                     (state == S_BSETUP) || (state == S_BRUN);
  assign bus.done  = (state == S_FIN);
  assign bus.dz_in = dz_r;
  assign bus.w_in  = w_r;
  assign bus.y_q   = y_r;
  assign bus.w_q   = wq_r;

endmodule

// File: doc/neuron_phase_ctrl.md
# neuron_phase_ctrl

Phase sequencer that drives a single-neuron datapath through its forward and backward passes via the two-bit `{fp,bp}` phase code. It holds the backward operands `dz_in` and `w_in` stable for the whole job, and captures the neuron's activation and updated weight/bias vector. It sits between the layer-level scheduler (start/done handshake) and one neuron instance.

## Interface
- `N`, 6: neuron input count; the weight vector is N+1 words (N weights plus bias).
- `BITS`, 16: word width, Q8.8 fixed point.
- `FWD_RUN`, N/2+4: number of forward-run cycles (phase 10), including pipeline drain.
- `BWD_RUN`, N+4: number of backward-run cycles (phase 01), including pipeline drain.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: job request, sampled only in IDLE.
- `train` in 1: sampled with `start`. 0 = forward only; 1 = forward then backward.
- `dz_up` in BITS: upstream gradient, captured on accepted `start`.
- `w_up` in BITS: upstream weight, captured on accepted `start`.
- `fp`, `bp` out 1 each: phase code to the neuron.
- `dz_in`, `w_in` out BITS: registered copies of `dz_up`/`w_up`, driven to the neuron.
- `y_nrn` in BITS: neuron activation output.
- `w_nrn` in (N+1)*BITS: neuron updated weight/bias vector.
- `y_q` out BITS: captured activation.
- `w_q` out (N+1)*BITS: captured updated weights.
- `busy` out 1: high while a job is in progress.
- `done` out 1: one-cycle completion pulse.
- `abort` in 1: present only with `NEURON_CTRL_ABORT_EN`.

## Operation
- States and phase codes:
  - IDLE (`{fp,bp}`=00, `busy`=0)
  - FSETUP (00)
  - FRUN (10)
  - BSETUP (11)
  - BRUN (01)
  - FIN (00, `busy`=0, `done`=1)
- Transitions:
  - IDLE -> FSETUP on `start`. The same edge captures `dz_up`/`w_up` and latches `train`.
  - FSETUP -> FRUN after 1 cycle.
  - FRUN lasts FWD_RUN cycles. On its last edge, `y_nrn` is captured into `y_q`. Next state is BSETUP if `train`, else FIN.
  - BSETUP -> BRUN after 1 cycle.
  - BRUN lasts BWD_RUN cycles. On its last edge, `w_nrn` is captured into `w_q`. Next state is FIN.
  - FIN -> IDLE after 1 cycle.
- Cycle counting: a down-counter is loaded with run length −1 on entry to each run state; the state exits when the counter reaches 0.
- Data paths: `dz_in`/`w_in` change only on an accepted `start`. `y_q`/`w_q` change only at their capture edges. The controller does no arithmetic; widths pass through unchanged.
- Boundary conditions:
  - `start` while not in IDLE is ignored, not queued.
  - `start` in the FIN cycle is ignored; it is accepted from the IDLE cycle after.
  - Forward-only job: `w_q` keeps its previous value.
- Reset values (`rst_n` low): state IDLE, `fp`=`bp`=0, `busy`=0, `done`=0, counter 0; `dz_in`, `w_in`, `y_q`, `w_q` all 0. Reset mid-job returns to IDLE immediately and aborts the job without a `done` pulse.

## Timing
- All outputs are registered; phase code, `busy` and `done` are decoded from the state register.
- `start` accepted at edge T0: FSETUP occupies cycle T0+1, and FRUN occupies T0+2 .. T0+1+FWD_RUN.
- Forward-only job: `done` in cycle T0+2+FWD_RUN; `busy` high for 1+FWD_RUN cycles.
- Training job: `done` in cycle T0+3+FWD_RUN+BWD_RUN; `busy` high for 2+FWD_RUN+BWD_RUN cycles.
- `y_q`/`w_q` are valid in the `done` cycle and hold until the next capture.

## Configuration
- `NEURON_CTRL_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort` high at any edge in a non-IDLE, non-FIN state forces FIN next cycle, with phase 00.
  - `done` still pulses; captures not yet reached are skipped.
  - `abort` in IDLE or FIN is ignored.
- Undefined: no `abort` port, and jobs always run to completion.

## Structure
- Shared package `nn_pkg`:
  - phase-code constants PH_FSETUP=2'b00, PH_FWD=2'b10, PH_BSETUP=2'b11, PH_BWD=2'b01
  - state enum `nn_ctrl_state_t`
  - `BITS` default
- Sub-module `nn_cycle_counter`: loadable down-counter with a zero flag, width $clog2(max(FWD_RUN,BWD_RUN)).

## Test plan
- Defaults, `train`=0, `start` at T0, stub `y_nrn`=16'h0180 -> phase 00 at T0+1, 10 for T0+2..T0+8, `done` at T0+9, `y_q`=16'h0180, `w_q` unchanged.
- `train`=1, `dz_up`=16'h0040, `w_up`=16'hFF80, `w_nrn`={7{16'h0100}} -> 11 at T0+9, 01 for T0+10..T0+19, `done` at T0+20, `dz_in`/`w_in` constant throughout, `w_q`={7{16'h0100}}.
- `start` held high for 30 cycles -> exactly two jobs; the second is accepted in the IDLE cycle after FIN.
- `rst_n` low at T0+5 of a training job -> all outputs 0 immediately; no `done`; the next `start` runs normally.
- With `NEURON_CTRL_ABORT_EN`, `abort` at T0+12 of a training job -> FIN at T0+13, `done` pulses, `y_q` updated, `w_q` unchanged.
- `start` while `busy`, and `start` in the FIN cycle -> ignored; `dz_in` unchanged.
